// File: rtl/l2_tlb_assoc.sv
// l2_tlb_assoc - set-associative second-level TLB.
//
// Holds WAYS translations per set (2^SET_W sets). A lookup accepted at a
// rising edge is answered by the registered rsp_* outputs during the
// following cycle. Fills pick their way in this order:
//   1. the way already holding the tag;
//   2. the lowest-index invalid way;
//   3. the tree pseudo-LRU victim.
// A flush runs a background sweep that clears one set per cycle.
//
// Optional feature macro: L2TLB_PARITY_EN. When it is defined, each entry
// keeps an even-parity bit over {tag, data}. A tag match whose parity is
// bad is reported as rsp_perr and that entry is invalidated. When the
// macro is undefined, rsp_perr is always 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   lk_valid   lookup request, taken when lk_ready=1
//   lk_ready   0 while the flush sweep runs (decoded from FSM state only)
//   lk_vpn     lookup VPN: {tag, set index}
//   rsp_valid  one-cycle response pulse
//   rsp_hit    valid tag match
//   rsp_data   payload of the hit way, 0 on a miss
//   rsp_perr   parity error on this lookup
//   fill_valid write translation; dropped during the sweep
//   fill_vpn   fill VPN: {tag, set index}
//   fill_data  fill payload
//   flush_req  start a full invalidate
//   flush_busy sweep in progress
module l2_tlb_assoc #(
    parameter int WAYS   = 4,
    parameter int SET_W  = 7,
    parameter int TAG_W  = 30,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lk_valid,
    output logic                   lk_ready,
    input  logic [SET_W+TAG_W-1:0] lk_vpn,
    output logic                   rsp_valid,
    output logic                   rsp_hit,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_perr,
    input  logic                   fill_valid,
    input  logic [SET_W+TAG_W-1:0] fill_vpn,
    input  logic [DATA_W-1:0]      fill_data,
    input  logic                   flush_req,
    output logic                   flush_busy
);

    localparam int SETS = 1 << SET_W;
    localparam int LW   = $clog2(WAYS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Tag and data arrays are never reset. Valid and PLRU state are reset.
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];
    logic [WAYS-2:0]   plru_d  [SETS];
`ifdef L2TLB_PARITY_EN
    logic              par_q   [SETS][WAYS];
`endif

    state_t            state_q, state_d;
    logic [SET_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_perr_q, rsp_perr_d;

    logic              lk_accept_s, fill_accept_s;
    logic [SET_W-1:0]  lk_set_s, fill_set_s;
    logic [TAG_W-1:0]  lk_tag_s, fill_tag_s;
    logic              lk_found_s, lk_hit_s, lk_perr_s;
    logic [LW-1:0]     lk_way_s;
    logic              fill_hit_s, fill_inv_s;
    logic [LW-1:0]     fill_hit_way_s, fill_inv_way_s, fill_way_s;

`ifdef L2TLB_PARITY_EN
    // Even parity: the stored bit makes the number of ones in {tag, data, p} even.
    function automatic logic entry_parity(input logic [TAG_W-1:0]  tag,
                                          input logic [DATA_W-1:0] data);
        return ^{tag, data};
    endfunction
`endif

    // Tree PLRU layout: node 0 is the root, and the children of node n are
    // 2n+1 and 2n+2. A node bit of 0 points the victim search left.
    // Way w is the victim when every node on its path points towards it.
    function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] tree);
        logic [LW-1:0] v;
        logic          on_path;
        int            node;
        int            dir;
        v = {LW{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            on_path = 1'b1;
            for (int l = 0; l < LW; l++) begin
                node    = (1 << l) - 1 + (w >> (LW - l));
                dir     = (w >> (LW - 1 - l)) & 1;
                on_path = on_path & (tree[node] == dir[0]);
            end
            v = on_path ? LW'(w) : v;
        end
        return v;
    endfunction

    // Point every node on the path of the accessed way away from that way.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                   input logic [LW-1:0]   way);
        logic [WAYS-2:0] r;
        int              node;
        r = tree;
        for (int l = 0; l < LW; l++) begin
            node    = (1 << l) - 1 + int'(way >> (LW - l));
            r[node] = ~way[LW-1-l];
        end
        return r;
    endfunction

    assign lk_ready      = (state_q == ST_IDLE);
    assign lk_accept_s   = lk_valid & lk_ready;
    assign fill_accept_s = fill_valid & (state_q == ST_IDLE);
    assign lk_set_s      = lk_vpn[SET_W-1:0];
    assign lk_tag_s      = lk_vpn[SET_W +: TAG_W];
    assign fill_set_s    = fill_vpn[SET_W-1:0];
    assign fill_tag_s    = fill_vpn[SET_W +: TAG_W];

    // Lookup tag compare on pre-fill contents; the lowest-index match wins.
    always_comb begin
        lk_found_s = 1'b0;
        lk_way_s   = {LW{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            lk_way_s   = (valid_q[lk_set_s][w] && (tag_q[lk_set_s][w] == lk_tag_s)) ? LW'(w) : lk_way_s;
            lk_found_s = lk_found_s | (valid_q[lk_set_s][w] && (tag_q[lk_set_s][w] == lk_tag_s));
        end
`ifdef L2TLB_PARITY_EN
        lk_perr_s = lk_found_s &
                    (entry_parity(tag_q[lk_set_s][lk_way_s], data_q[lk_set_s][lk_way_s])
                     != par_q[lk_set_s][lk_way_s]);
`else
        lk_perr_s = 1'b0;
`endif
        lk_hit_s = lk_found_s & ~lk_perr_s;
    end

    // Fill way selection: existing tag, else lowest invalid way, else PLRU victim.
    always_comb begin
        fill_hit_s     = 1'b0;
        fill_hit_way_s = {LW{1'b0}};
        fill_inv_s     = 1'b0;
        fill_inv_way_s = {LW{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            fill_hit_way_s = (valid_q[fill_set_s][w] && (tag_q[fill_set_s][w] == fill_tag_s)) ? LW'(w) : fill_hit_way_s;
            fill_hit_s     = fill_hit_s | (valid_q[fill_set_s][w] && (tag_q[fill_set_s][w] == fill_tag_s));
            fill_inv_way_s = (!valid_q[fill_set_s][w]) ? LW'(w) : fill_inv_way_s;
            fill_inv_s     = fill_inv_s | !valid_q[fill_set_s][w];
        end
        if (fill_hit_s) begin
            fill_way_s = fill_hit_way_s;
        end else if (fill_inv_s) begin
            fill_way_s = fill_inv_way_s;
        end else begin
            fill_way_s = plru_victim(plru_q[fill_set_s]);
        end
    end

    // Next valid/PLRU state: the sweep clears one set; otherwise apply lookup then fill effects.
    always_comb begin
        valid_d = valid_q;
        plru_d  = plru_q;
        if (state_q == ST_SWEEP) begin
            valid_d[sweep_cnt_q] = {WAYS{1'b0}};
            plru_d[sweep_cnt_q]  = {(WAYS-1){1'b0}};
        end else begin
            if (lk_accept_s && lk_perr_s) begin
                valid_d[lk_set_s][lk_way_s] = 1'b0;
            end else begin
                valid_d[lk_set_s][lk_way_s] = valid_q[lk_set_s][lk_way_s];
            end
            // A fill to the same set owns that set's PLRU update this cycle.
            if (lk_accept_s && lk_hit_s && !(fill_accept_s && (fill_set_s == lk_set_s))) begin
                plru_d[lk_set_s] = plru_touch(plru_q[lk_set_s], lk_way_s);
            end else begin
                plru_d[lk_set_s] = plru_q[lk_set_s];
            end
            if (fill_accept_s) begin
                valid_d[fill_set_s][fill_way_s] = 1'b1;
                plru_d[fill_set_s]              = plru_touch(plru_q[fill_set_s], fill_way_s);
            end else begin
                valid_d[fill_set_s] = valid_d[fill_set_s];
            end
        end
    end

    // Flush FSM next state and sweep counter.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = {SET_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                sweep_cnt_d = sweep_cnt_q + {{(SET_W-1){1'b0}}, 1'b1};
                if (sweep_cnt_q == {SET_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sweep_cnt_d = {SET_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
    end

    // Response next values; a miss or parity error returns zero data.
    always_comb begin
        rsp_valid_d = lk_accept_s;
        rsp_hit_d   = lk_accept_s & lk_hit_s;
        rsp_perr_d  = lk_accept_s & lk_perr_s;
        if (lk_accept_s && lk_hit_s) begin
            rsp_data_d = data_q[lk_set_s][lk_way_s];
        end else begin
            rsp_data_d = {DATA_W{1'b0}};
        end
    end

    // Control, valid and PLRU registers; reset clears everything, including a sweep in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sweep_cnt_q <= {SET_W{1'b0}};
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_perr_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
                plru_q[s]  <= {(WAYS-1){1'b0}};
            end
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
            rsp_perr_q  <= rsp_perr_d;
            valid_q     <= valid_d;
            plru_q      <= plru_d;
        end
    end

    // Entry storage write on an accepted fill (no reset on tag/data).
    always_ff @(posedge clk) begin
        if (fill_accept_s) begin
            tag_q[fill_set_s][fill_way_s]  <= fill_tag_s;
            data_q[fill_set_s][fill_way_s] <= fill_data;
`ifdef L2TLB_PARITY_EN
            par_q[fill_set_s][fill_way_s]  <= entry_parity(fill_tag_s, fill_data);
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_perr   = rsp_perr_q;
    assign flush_busy = busy_q;

endmodule

// File: tb/tb_l2_tlb_assoc.sv
// Directed self-checking bench for l2_tlb_assoc with the default parameters
// (WAYS=4, SET_W=7, TAG_W=30, DATA_W=64). Inputs change 1ns after a rising
// edge, and outputs are sampled at that same point.
module tb_l2_tlb_assoc;

    localparam int WAYS   = 4;
    localparam int SET_W  = 7;
    localparam int TAG_W  = 30;
    localparam int DATA_W = 64;
    localparam int VPN_W  = SET_W + TAG_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              lk_valid;
    logic              lk_ready;
    logic [VPN_W-1:0]  lk_vpn;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_perr;
    logic              fill_valid;
    logic [VPN_W-1:0]  fill_vpn;
    logic [DATA_W-1:0] fill_data;
    logic              flush_req;
    logic              flush_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_tlb_assoc #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_vpn     (lk_vpn),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_data   (rsp_data),
        .rsp_perr   (rsp_perr),
        .fill_valid (fill_valid),
        .fill_vpn   (fill_vpn),
        .fill_data  (fill_data),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    function automatic logic [VPN_W-1:0] mk(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set);
        return {tag, set};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [VPN_W-1:0] v, input logic [DATA_W-1:0] d);
        fill_valid = 1'b1;
        fill_vpn   = v;
        fill_data  = d;
        step();
        fill_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [VPN_W-1:0] v, output logic vld, output logic hit,
                             output logic [DATA_W-1:0] data, output logic perr);
        lk_valid = 1'b1;
        lk_vpn   = v;
        step();
        lk_valid = 1'b0;
        vld  = rsp_valid;
        hit  = rsp_hit;
        data = rsp_data;
        perr = rsp_perr;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_hit, rsp_data, rsp_perr} !== {1'b0, 1'b0, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b h=%b d=%h p=%b, want all 0", rsp_valid, rsp_hit, rsp_data, rsp_perr);
        end
        checks++;
        if ({flush_busy, lk_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b ready=%b, want busy=0 ready=1", flush_busy, lk_ready);
        end
        #2 rst = 1'b1;
        step();
        checks++;
        if ({rsp_valid, flush_busy, lk_ready} !== 3'b001) begin
            errors++;
            $display("FAIL post_reset: got v=%b busy=%b ready=%b, want 0 0 1", rsp_valid, flush_busy, lk_ready);
        end
    endtask

    task automatic test_lookup_miss();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        do_lookup(37'h00_0000_012A, v, h, d, p);
        checks++;
        if ({v, h, d, p} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL cold_miss: got v=%b h=%b d=%h p=%b, want 1 0 0 0", v, h, d, p);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: got rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_fill_hit();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        do_fill(37'h155, 64'hDEAD_BEEF);
        do_lookup(37'h155, v, h, d, p);
        checks++;
        if ({v, h, d, p} !== {1'b1, 1'b1, 64'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL fill_hit: got v=%b h=%b d=%h p=%b, want 1 1 deadbeef 0", v, h, d, p);
        end
    endtask

    task automatic test_back_to_back();
        logic [VPN_W-1:0]  vpns [3];
        logic              exp_h [3];
        logic [DATA_W-1:0] exp_d [3];
        vpns[0] = 37'h155; exp_h[0] = 1'b1; exp_d[0] = 64'hDEAD_BEEF;
        vpns[1] = 37'h12A; exp_h[1] = 1'b0; exp_d[1] = 64'h0;
        vpns[2] = 37'h155; exp_h[2] = 1'b1; exp_d[2] = 64'hDEAD_BEEF;
        lk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lk_vpn = vpns[i];
            step();
            checks++;
            if ({rsp_valid, rsp_hit, rsp_data} !== {1'b1, exp_h[i], exp_d[i]}) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b h=%b d=%h, want 1 %b %h", i, rsp_valid, rsp_hit, rsp_data, exp_h[i], exp_d[i]);
            end
        end
        lk_valid = 1'b0;
    endtask

    // Ways 0-3 of set 3 receive tags 0x101-0x104. The PLRU then points at way 0, so 0x105 evicts 0x101.
    task automatic test_plru_evict();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        logic              eh;
        logic [DATA_W-1:0] ed;
        for (int t = 1; t <= 5; t++) begin
            do_fill(mk(30'(32'h100 + t), 7'd3), 64'(64'hA000 + t));
        end
        for (int t = 1; t <= 5; t++) begin
            do_lookup(mk(30'(32'h100 + t), 7'd3), v, h, d, p);
            eh = (t != 1);
            ed = (t != 1) ? 64'(64'hA000 + t) : 64'h0;
            checks++;
            if ({v, h, d} !== {1'b1, eh, ed}) begin
                errors++;
                $display("FAIL evict_tag%0d: got v=%b h=%b d=%h, want 1 %b %h", t, v, h, d, eh, ed);
            end
        end
    endtask

    // Touching way 0 makes the PLRU point root->right and node2->left, so way 2 (0x203) is the victim.
    task automatic test_plru_protect();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        for (int t = 1; t <= 4; t++) begin
            do_fill(mk(30'(32'h200 + t), 7'd5), 64'(64'hB000 + t));
        end
        do_lookup(mk(30'h201, 7'd5), v, h, d, p);
        checks++;
        if ({v, h, d} !== {1'b1, 1'b1, 64'hB001}) begin
            errors++;
            $display("FAIL protect_touch: got v=%b h=%b d=%h, want 1 1 b001", v, h, d);
        end
        do_fill(mk(30'h205, 7'd5), 64'hB005);
        do_lookup(mk(30'h201, 7'd5), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b1, 64'hB001}) begin
            errors++;
            $display("FAIL protect_way0: got h=%b d=%h, want 1 b001", h, d);
        end
        do_lookup(mk(30'h203, 7'd5), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL protect_victim: got h=%b d=%h, want 0 0", h, d);
        end
        do_lookup(mk(30'h205, 7'd5), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b1, 64'hB005}) begin
            errors++;
            $display("FAIL protect_new: got h=%b d=%h, want 1 b005", h, d);
        end
    endtask

    task automatic test_overwrite();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        do_fill(mk(30'h201, 7'd5), 64'hBBBB);
        do_lookup(mk(30'h201, 7'd5), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b1, 64'hBBBB}) begin
            errors++;
            $display("FAIL overwrite_data: got h=%b d=%h, want 1 bbbb", h, d);
        end
        do_lookup(mk(30'h204, 7'd5), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b1, 64'hB004}) begin
            errors++;
            $display("FAIL overwrite_neighbour: got h=%b d=%h, want 1 b004", h, d);
        end
    endtask

    task automatic test_same_cycle();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        lk_valid   = 1'b1;
        lk_vpn     = mk(30'h301, 7'd9);
        fill_valid = 1'b1;
        fill_vpn   = mk(30'h301, 7'd9);
        fill_data  = 64'hC301;
        step();
        lk_valid   = 1'b0;
        fill_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_hit, rsp_data} !== {1'b1, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL same_cycle_prefill: got v=%b h=%b d=%h, want 1 0 0", rsp_valid, rsp_hit, rsp_data);
        end
        do_lookup(mk(30'h301, 7'd9), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b1, 64'hC301}) begin
            errors++;
            $display("FAIL same_cycle_after: got h=%b d=%h, want 1 c301", h, d);
        end
    endtask

    task automatic test_flush();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        int cnt;
        lk_valid  = 1'b1;
        lk_vpn    = 37'h155;
        flush_req = 1'b1;
        step();
        lk_valid  = 1'b0;
        flush_req = 1'b0;
        checks++;
        if ({rsp_valid, rsp_hit, rsp_data} !== {1'b1, 1'b1, 64'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL flush_start_lookup: got v=%b h=%b d=%h, want 1 1 deadbeef", rsp_valid, rsp_hit, rsp_data);
        end
        checks++;
        if ({flush_busy, lk_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_start_ctrl: got busy=%b ready=%b, want 1 0", flush_busy, lk_ready);
        end
        cnt = 0;
        while (flush_busy === 1'b1 && cnt < 300) begin
            cnt++;
            // Set 2 has already been swept, so a fill that got through would survive.
            if (cnt == 10) begin
                fill_valid = 1'b1;
                fill_vpn   = mk(30'h401, 7'd2);
                fill_data  = 64'hD401;
            end
            if (cnt == 11) fill_valid = 1'b0;
            if (cnt == 20) flush_req = 1'b1;
            if (cnt == 21) flush_req = 1'b0;
            if (cnt == 30) begin
                lk_valid = 1'b1;
                lk_vpn   = 37'h155;
            end
            if (cnt == 31) begin
                lk_valid = 1'b0;
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_no_lookup: got rsp_valid=%b, want 0", rsp_valid);
                end
            end
            step();
        end
        checks++;
        if (cnt != 128) begin
            errors++;
            $display("FAIL flush_duration: got %0d busy cycles, want 128", cnt);
        end
        checks++;
        if (lk_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_end_ready: got lk_ready=%b, want 1", lk_ready);
        end
        do_lookup(37'h155, v, h, d, p);
        checks++;
        if ({v, h, d} !== {1'b1, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL flush_miss_155: got v=%b h=%b d=%h, want 1 0 0", v, h, d);
        end
        do_lookup(mk(30'h401, 7'd2), v, h, d, p);
        checks++;
        if (h !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill_dropped: got h=%b, want 0", h);
        end
        do_lookup(mk(30'h105, 7'd3), v, h, d, p);
        checks++;
        if (h !== 1'b0) begin
            errors++;
            $display("FAIL flush_miss_set3: got h=%b, want 0", h);
        end
        do_lookup(mk(30'h301, 7'd9), v, h, d, p);
        checks++;
        if (h !== 1'b0) begin
            errors++;
            $display("FAIL flush_miss_set9: got h=%b, want 0", h);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        do_fill(mk(30'h501, 7'd8), 64'hE501);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({flush_busy, lk_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_sweep_reset: got busy=%b ready=%b, want 0 1", flush_busy, lk_ready);
        end
        step();
        #2 rst = 1'b1;
        do_lookup(mk(30'h501, 7'd8), v, h, d, p);
        checks++;
        if ({v, h} !== 2'b10) begin
            errors++;
            $display("FAIL mid_sweep_cleared: got v=%b h=%b, want 1 0", v, h);
        end
        do_fill(mk(30'h502, 7'd8), 64'hE502);
        do_lookup(mk(30'h502, 7'd8), v, h, d, p);
        checks++;
        if ({h, d} !== {1'b1, 64'hE502}) begin
            errors++;
            $display("FAIL mid_sweep_refill: got h=%b d=%h, want 1 e502", h, d);
        end
    endtask

`ifdef L2TLB_PARITY_EN
    task automatic test_parity();
        logic v, h, p;
        logic [DATA_W-1:0] d;
        do_fill(mk(30'h77, 7'h11), 64'h1234);
        dut.data_q[7'h11][0][0] = ~dut.data_q[7'h11][0][0];
        do_lookup(mk(30'h77, 7'h11), v, h, d, p);
        checks++;
        if ({v, h, p} !== 3'b101) begin
            errors++;
            $display("FAIL parity_detect: got v=%b h=%b p=%b, want 1 0 1", v, h, p);
        end
        do_lookup(mk(30'h77, 7'h11), v, h, d, p);
        checks++;
        if ({v, h, p} !== 3'b100) begin
            errors++;
            $display("FAIL parity_invalidated: got v=%b h=%b p=%b, want 1 0 0", v, h, p);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lk_valid   = 1'b0;
        lk_vpn     = '0;
        fill_valid = 1'b0;
        fill_vpn   = '0;
        fill_data  = '0;
        flush_req  = 1'b0;
        test_reset();
        test_lookup_miss();
        test_fill_hit();
        test_back_to_back();
        test_plru_evict();
        test_plru_protect();
        test_overwrite();
        test_same_cycle();
        test_flush();
        test_reset_mid_sweep();
`ifdef L2TLB_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_tlb_assoc.md
# l2_tlb_assoc

Parametrised set-associative second-level TLB: the successor to the fixed 128-entry direct-indexed dtlb2 RAM + LRU RAM pair. It stores `WAYS` translations per set and answers lookups with a registered hit/data response one cycle later. It allocates fills with tree pseudo-LRU and supports a full flush via a background set-sweep state machine. It sits between the L1 DTLB miss path and the page walker.

## Interface
- `WAYS`, default 4: associativity; power of two, 2..8.
- `SET_W`, default 7: set index width; sets = 2^SET_W.
- `TAG_W`, default 30: tag width. VPN width is `SET_W+TAG_W`; index = VPN[SET_W-1:0], tag = upper bits.
- `DATA_W`, default 64: translation payload width.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `lk_valid`  input  1  lookup request, sampled when `lk_ready`=1.
- `lk_ready`  output  1  0 while flush sweep is active.
- `lk_vpn`  input  SET_W+TAG_W  lookup VPN.
- `rsp_valid`  output  1  lookup response valid, one-cycle pulse.
- `rsp_hit`  output  1  tag matched a valid way.
- `rsp_data`  output  DATA_W  payload of the hit way; 0 on miss.
- `rsp_perr`  output  1  parity error detected on this lookup.
- `fill_valid`  input  1  write translation; always accepted except during a sweep, when it is dropped.
- `fill_vpn`  input  SET_W+TAG_W  fill VPN.
- `fill_data`  input  DATA_W  fill payload.
- `flush_req`  input  1  start a full invalidate.
- `flush_busy`  output  1  sweep in progress.

## Operation
- Storage:
  - Per-way tag/data arrays: no reset.
  - Valid bits: `WAYS x 2^SET_W` flops with reset.
  - PLRU: `WAYS-1` bits per set, flops with reset.
- Lookup: compare the tag against all ways of the indexed set. Matching valid way → hit.
  - Multiple matches are illegal (prevented by the fill rule). The lowest-index match wins.
- PLRU update on hit and on fill: the tree bits on the path point away from the accessed way.
- Fill victim selection:
  - If `fill_vpn` already hits: overwrite that way's data. No duplicate is created.
  - Else: lowest-index invalid way.
  - Else: PLRU victim.
  - Set the valid bit and update PLRU.
- Same cycle fill + lookup:
  - The lookup sees pre-fill contents; no forwarding.
  - If both target the same set, only the fill's PLRU update is applied.
- Flush FSM, states IDLE and SWEEP:
  - IDLE → SWEEP on `flush_req`; the set counter is loaded to 0.
  - SWEEP: each cycle, clear all valid bits and PLRU bits of set[counter], then increment.
  - Counter = 2^SET_W-1 → IDLE after clearing that set; the counter wraps to 0.
  - `flush_req` while in SWEEP is ignored.
  - During SWEEP, lookups are not accepted and fills are dropped.
- Reset mid-sweep: FSM returns to IDLE and all valid bits are cleared asynchronously.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_hit`=0, `rsp_data`=0, `rsp_perr`=0.
  - `flush_busy`=0, `lk_ready`=1.
  - FSM = IDLE, counter = 0, all valid/PLRU = 0.
- Lookup latency 1: request accepted at edge N → `rsp_*` valid for the cycle after edge N. Throughput is one lookup per cycle.
- Fill visibility: a fill written at edge N is visible to a lookup accepted at edge N+1.
- Flush:
  - `flush_req` sampled at edge N → `flush_busy`=1 and `lk_ready`=0 from N until edge N+2^SET_W.
  - Sweep duration is exactly 2^SET_W cycles.
- A lookup accepted at the same edge that starts the sweep still returns its response (pre-flush contents).
- `lk_ready` is combinational from FSM state only.

## Configuration
- `L2TLB_PARITY_EN` defined:
  - Each entry stores one even-parity bit over {tag, data}, written on fill.
  - A tag match with bad parity reports `rsp_hit`=0 and `rsp_perr`=1.
  - That way's valid bit is cleared on the response edge.
- Not defined: no parity storage; `rsp_perr` is tied to 0.

## Test plan
- Reset, then lookup VPN 0x0000_0001_2A → `rsp_valid`=1, `rsp_hit`=0, `rsp_data`=0 one cycle later.
- Fill VPN 0x155 with data 0xDEAD_BEEF, then lookup 0x155 the next cycle → hit, `rsp_data`=0xDEAD_BEEF.
- Fill 5 distinct tags into set 3 (WAYS=4) with no intervening lookups → the first-filled tag (way 0, the PLRU victim) is evicted. Lookup of tag 1 misses; tags 2-5 hit.
- Fill ways 0-3 of set 3, lookup the way-0 tag, then fill a new tag → the victim is not way 0; the way-0 tag still hits.
- Fill, then pulse `flush_req`:
  - `flush_busy` stays 1 for 128 cycles (SET_W=7).
  - Fills during the sweep are dropped.
  - All lookups afterwards miss.
- With `L2TLB_PARITY_EN`: fill, force-flip one data bit, lookup → `rsp_hit`=0, `rsp_perr`=1; a repeat lookup gives `rsp_hit`=0, `rsp_perr`=0.
